// File: rtl/word_to_block_deser.sv
// word_to_block_deser
//   Assembles N = BLOCK_W/IN_W words, strobed in by an asynchronous host
//   load pin, into one BLOCK_W-bit block. The block is offered to the hash
//   core over a ready/valid handshake. One full block can wait behind the
//   output register (PEND).
//
//   Optional feature macro: DESER_TIMEOUT_EN
//     Defined:   a partial block that sees no capture for TIMEOUT_CYC cycles
//                (while in_en = 1) is discarded, and timeout_err pulses.
//     Undefined: a partial block waits indefinitely; timeout_err is tied 0.
//
//   Ports
//     clk, rst_p   system clock; asynchronous active-high reset
//     in_en        accept strobes (low: ignore them and keep all state)
//     load         asynchronous host strobe; each rising edge is one word
//     part_in      host word, stable around the load rising edge
//     msb_first    1: word 0 lands in the top IN_W bits; sampled at word 0
//     block        assembled block
//     block_valid  block holds a complete, unconsumed block
//     block_ready  consumer accepts when block_valid & block_ready
//     word_cnt     words captured into the current partial block
//     overflow     sticky: a word was dropped while a block was pending
//     timeout_err  one-cycle pulse: a partial block was discarded

// One word slot of the assembly register. nxt exposes the value the slot
// takes at the coming edge, so a block that completes this cycle can be
// loaded into the output register at the same edge.
module word_to_block_slot #(
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            rst_p,
  input  logic            we,
  input  logic [IN_W-1:0] din,
  output logic [IN_W-1:0] q,
  output logic [IN_W-1:0] nxt
);
  assign nxt = we ? din : q;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) q <= '0;
    else       q <= nxt;
  end
endmodule

module word_to_block_deser #(
  parameter int IN_W        = 8,
  parameter int BLOCK_W     = 256,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_p,
  input  logic                                  in_en,
  input  logic                                  load,
  input  logic [IN_W-1:0]                       part_in,
  input  logic                                  msb_first,
  output logic [BLOCK_W-1:0]                    block,
  output logic                                  block_valid,
  input  logic                                  block_ready,
  output logic [$clog2(BLOCK_W/IN_W)-1:0]       word_cnt,
  output logic                                  overflow,
  output logic                                  timeout_err
);
  localparam int N  = BLOCK_W / IN_W;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, FILL, PEND} state_t;
  state_t state;

  // Strobe synchronizer plus delay flop for rising-edge detect. Runs
  // regardless of in_en so re-enabling never fabricates an edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   ld_edge;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], load};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ld_edge = sync_q[SYNC_STAGES-1] & ~dly_q;

  logic cap, last, hs, out_free, order_q, order;
  logic [CW-1:0] slot_idx;

  assign cap      = ld_edge & in_en & (state != PEND);
  assign last     = cap & (word_cnt == CW'(N-1));
  assign hs       = block_valid & block_ready;
  assign out_free = ~block_valid | block_ready;
  // Word 0 takes its order from the pin; later words use the latched order.
  assign order    = (state == IDLE) ? msb_first : order_q;
  assign slot_idx = order ? (CW'(N-1) - word_cnt) : word_cnt;

  // Assembly register: slot p holds bits [p*IN_W +: IN_W] of the block.
  logic [N-1:0][IN_W-1:0] slot_q, slot_nxt;
  logic [N-1:0]           slot_we;

  for (genvar p = 0; p < N; p++) begin : g_slot
    assign slot_we[p] = cap & (slot_idx == CW'(p));
    word_to_block_slot #(.IN_W(IN_W)) u_slot (
      .clk   (clk),
      .rst_p (rst_p),
      .we    (slot_we[p]),
      .din   (part_in),
      .q     (slot_q[p]),
      .nxt   (slot_nxt[p])
    );
  end

`ifdef DESER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state       <= IDLE;
      word_cnt    <= '0;
      order_q     <= 1'b0;
      block       <= '0;
      block_valid <= 1'b0;
      overflow    <= 1'b0;
`ifdef DESER_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef DESER_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      if (ld_edge & in_en & (state == PEND)) overflow <= 1'b1;
      // Consumed block drops valid unless a new block is loaded below.
      if (hs) block_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cap) begin
            order_q  <= msb_first;
            word_cnt <= CW'(1);
            state    <= FILL;
`ifdef DESER_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end
        FILL: begin
          if (cap) begin
`ifdef DESER_TIMEOUT_EN
            to_cnt <= '0;
`endif
            if (last) begin
              word_cnt <= '0;
              if (out_free) begin
                block       <= slot_nxt;
                block_valid <= 1'b1;
                state       <= IDLE;
              end else begin
                state <= PEND;
              end
            end else begin
              word_cnt <= word_cnt + CW'(1);
            end
          end
`ifdef DESER_TIMEOUT_EN
          else if (in_en) begin
            if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
              to_cnt      <= '0;
              word_cnt    <= '0;
              state       <= IDLE;
              timeout_err <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
`endif
        end
        PEND: begin
          // block_valid is necessarily 1 here; hand over without a bubble.
          if (hs) begin
            block       <= slot_q;
            block_valid <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_word_to_block_deser.sv
module tb_word_to_block_deser;
  logic         clk = 1'b0;
  logic         rst_p, in_en, load, msb_first, block_ready;
  logic [7:0]   part_in;
  logic [255:0] block;
  logic         block_valid, overflow, timeout_err;
  logic [4:0]   word_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] BLK_A_MSB = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] BLK_A_LSB = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [255:0] BLK_B_MSB = 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f;
  localparam logic [255:0] BLK_C_LSB = 256'h5f5e5d5c5b5a595857565554535251504f4e4d4c4b4a49484746454443424140;
  localparam logic [255:0] BLK_D_MSB = 256'he0e1e2e3e405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  word_to_block_deser #(
    .IN_W(8), .BLOCK_W(256), .SYNC_STAGES(2), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_p(rst_p), .in_en(in_en), .load(load), .part_in(part_in),
    .msb_first(msb_first), .block(block), .block_valid(block_valid),
    .block_ready(block_ready), .word_cnt(word_cnt), .overflow(overflow),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // One host strobe: high 4 cycles, low 4 cycles. Starts and ends on a negedge.
  task automatic strobe(input logic [7:0] w);
    part_in = w;
    load = 1'b1;
    repeat (4) @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) strobe(base + 8'(i));
  endtask

  task automatic do_reset();
    rst_p = 1'b1;
    repeat (2) @(negedge clk);
    rst_p = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_p = 1'b1; in_en = 1'b1; load = 1'b0; part_in = 8'h00;
    msb_first = 1'b1; block_ready = 1'b1;
    #2;
    checks++;
    if ({block_valid, overflow, timeout_err, word_cnt} !== 8'h00 || block !== '0) begin
      $display("FAIL reset_outputs: valid=%b ovf=%b to=%b cnt=%0d block=%h expected all 0",
               block_valid, overflow, timeout_err, word_cnt, block);
      failures++;
    end
    repeat (2) @(negedge clk);
    rst_p = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_msb_first();
    msb_first = 1'b1; block_ready = 1'b1;
    send(8'h00, 31);
    checks++;
    if (word_cnt !== 5'd31) begin
      $display("FAIL msb_cnt31: got %0d expected 31", word_cnt); failures++;
    end
    part_in = 8'h1f; load = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (block_valid !== 1'b0) begin
      $display("FAIL msb_valid_early: got %b expected 0", block_valid); failures++;
    end
    @(negedge clk);
    checks++;
    if (block_valid !== 1'b1 || block !== BLK_A_MSB) begin
      $display("FAIL msb_block: valid=%b block=%h expected valid=1 block=%h",
               block_valid, block, BLK_A_MSB); failures++;
    end
    @(negedge clk);
    checks++;
    if (block_valid !== 1'b0 || word_cnt !== 5'd0) begin
      $display("FAIL msb_valid_pulse: valid=%b cnt=%0d expected 0/0", block_valid, word_cnt);
      failures++;
    end
    load = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_lsb_first();
    msb_first = 1'b0; block_ready = 1'b1;
    send(8'h00, 32);
    checks++;
    if (block !== BLK_A_LSB || block[7:0] !== 8'h00 || block[255:248] !== 8'h1f) begin
      $display("FAIL lsb_block: got %h expected %h", block, BLK_A_LSB); failures++;
    end
    checks++;
    if (word_cnt !== 5'd0 || block_valid !== 1'b0) begin
      $display("FAIL lsb_idle: cnt=%0d valid=%b expected 0/0", word_cnt, block_valid);
      failures++;
    end
  endtask

  task automatic test_backpressure();
    msb_first = 1'b1; block_ready = 1'b0;
    send(8'h00, 32);
    send(8'h20, 32);
    checks++;
    if (block_valid !== 1'b1 || block !== BLK_A_MSB || overflow !== 1'b0 || word_cnt !== 5'd0) begin
      $display("FAIL bp_hold: valid=%b ovf=%b cnt=%0d block=%h expected 1/0/0 %h",
               block_valid, overflow, word_cnt, block, BLK_A_MSB); failures++;
    end
    strobe(8'haa);
    checks++;
    if (overflow !== 1'b1 || block !== BLK_A_MSB || block_valid !== 1'b1) begin
      $display("FAIL bp_overflow: ovf=%b valid=%b block=%h expected 1/1 %h",
               overflow, block_valid, block, BLK_A_MSB); failures++;
    end
    block_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (block_valid !== 1'b1 || block !== BLK_B_MSB) begin
      $display("FAIL bp_no_bubble: valid=%b block=%h expected 1 %h", block_valid, block, BLK_B_MSB);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (block_valid !== 1'b0 || overflow !== 1'b1) begin
      $display("FAIL bp_drain: valid=%b ovf=%b expected 0/1", block_valid, overflow); failures++;
    end
  endtask

  task automatic test_level_and_enable();
    do_reset();
    part_in = 8'h55; load = 1'b1;
    repeat (50) @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (word_cnt !== 5'd1) begin
      $display("FAIL level_one_capture: cnt=%0d expected 1", word_cnt); failures++;
    end
    in_en = 1'b0;
    send(8'h60, 3);
    in_en = 1'b1;
    checks++;
    if (word_cnt !== 5'd1 || overflow !== 1'b0) begin
      $display("FAIL in_en_ignore: cnt=%0d ovf=%b expected 1/0", word_cnt, overflow); failures++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    msb_first = 1'b1; block_ready = 1'b0;
    send(8'h00, 32);
    send(8'h70, 10);
    checks++;
    if (word_cnt !== 5'd10 || block !== BLK_A_MSB) begin
      $display("FAIL pre_reset: cnt=%0d block=%h expected 10 %h", word_cnt, block, BLK_A_MSB);
      failures++;
    end
    #3 rst_p = 1'b1;
    #1;
    checks++;
    if ({block_valid, overflow, timeout_err, word_cnt} !== 8'h00 || block !== '0) begin
      $display("FAIL async_reset: valid=%b ovf=%b to=%b cnt=%0d block=%h expected all 0",
               block_valid, overflow, timeout_err, word_cnt, block); failures++;
    end
    @(negedge clk);
    rst_p = 1'b0;
    @(negedge clk);
    msb_first = 1'b0; block_ready = 1'b1;
    send(8'h40, 32);
    checks++;
    if (block !== BLK_C_LSB || word_cnt !== 5'd0) begin
      $display("FAIL post_reset_block: cnt=%0d block=%h expected 0 %h", word_cnt, block, BLK_C_LSB);
      failures++;
    end
  endtask

  task automatic test_timeout();
    int n;
    logic seen;
    do_reset();
    msb_first = 1'b1; block_ready = 1'b1;
    send(8'he0, 4);
    part_in = 8'he4; load = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b0;
`ifdef DESER_TIMEOUT_EN
    n = 41;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n !== 16) begin
      $display("FAIL timeout_latency: pulse after %0d idle cycles expected 16", n); failures++;
    end
    checks++;
    if (word_cnt !== 5'd0) begin
      $display("FAIL timeout_cnt: cnt=%0d expected 0", word_cnt); failures++;
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      $display("FAIL timeout_pulse_width: got %b expected 0", timeout_err); failures++;
    end
    repeat (4) @(negedge clk);
    send(8'h20, 32);
    checks++;
    if (block !== BLK_B_MSB) begin
      $display("FAIL timeout_next_block: got %h expected %h", block, BLK_B_MSB); failures++;
    end
`else
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout_err !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || word_cnt !== 5'd5) begin
      $display("FAIL no_timeout_hold: to_seen=%b cnt=%0d expected 0/5", seen, word_cnt);
      failures++;
    end
    send(8'h05, 27);
    checks++;
    if (block !== BLK_D_MSB) begin
      $display("FAIL no_timeout_block: got %h expected %h", block, BLK_D_MSB); failures++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_level_and_enable();
    test_async_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
